seg_scan_controller: RTL

Time-multiplexed scan controller for the common-anode 7-segment display bank. It divides the system clock into per-digit scan slots and drives one anode at a time. Each slot starts with a blanking interval to suppress ghosting. It decodes hex nibbles to segment patterns, applies per-digit enable and leading-zero suppression, and latches the display value only at frame boundaries so the display never shows a torn value.

---
 rtl/seg_scan_controller_if.sv | 25 ++
 rtl/seg_scan_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - display value inputs and scan outputs of the 7-segment controller
interface seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  // Host side: supplies the value to show, observes the scan
  modport master (
    output value, dp_in, digit_en, lz_suppress,
    input  an, seg, dp, frame_start
  );

  // Controller side
  modport slave (
    input  value, dp_in, digit_en, lz_suppress,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - multiplexed 7-segment scan with blanking, hex decode and tear-free latching
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic clk_in,
  input logic rst,
  seg_scan_controller_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  // With no blanking interval a slot opens directly in DRIVE
  localparam state_t SLOT_FIRST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  state_t                  state;
  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lz;

  logic                    frame_start_int;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_act;
  logic                    dp_act;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

  // Slot timing: count SCAN_DIV cycles per digit, BLANK then DRIVE, advance digit at slot end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= SLOT_FIRST;
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == CNT_LAST) begin
      slot_cnt <= '0;
      state    <= SLOT_FIRST;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (state == ST_BLANK && slot_cnt == BLANK_LAST)
        state <= ST_DRIVE;
    end
  end

  // First cycle of digit 0's slot; held low while reset is asserted
  assign frame_start_int = !rst && (slot_cnt == '0) && (idx == '0);
  assign bus.frame_start = frame_start_int;

  // Shadow copy of the display inputs, refreshed only at frame boundaries
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
      sh_lz    <= 1'b0;
    end else if (frame_start_int) begin
      sh_value <= bus.value;
      sh_dp    <= bus.dp_in;
      sh_en    <= bus.digit_en;
      sh_lz    <= bus.lz_suppress;
    end
  end

  // Split nibbles and mark leading zeros, scanning from the most significant digit down
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]   = sh_value[4*i +: 4];
      zero_run = zero_run && (nib[i] == 4'h0);
      supp[i]  = sh_lz && zero_run && (i != 0);
    end
  end

  // Drive the current digit only in DRIVE, when enabled and not suppressed
  always_comb begin
    lit     = (state == ST_DRIVE) && sh_en[idx] && !supp[idx];
    an_act  = lit ? (NUM_DIGITS'(1) << idx) : '0;
    seg_act = lit ? hex_to_seg(nib[idx]) : 7'b0;
    dp_act  = lit && sh_dp[idx];
  end

  assign bus.an  = an_act  ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign bus.seg = seg_act ^ {7{ACTIVE_LOW}};
  assign bus.dp  = dp_act  ^ ACTIVE_LOW;

endmodule
